// File: rtl/pet2001_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pet2001_pkg : PS/2 prefix bytes, decoder states, PET matrix geometry |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pet2001_pkg;

   localparam logic [7:0] c_ps2_f0  = 8'hF0;
   localparam logic [7:0] c_ps2_e0  = 8'hE0;
   localparam logic [7:0] c_ps2_e1  = 8'hE1;
   localparam logic [7:0] c_ps2_bat = 8'hAA;
   localparam logic [7:0] c_ps2_ack = 8'hFA;
   localparam logic [7:0] c_ps2_rsd = 8'hFE;
   localparam logic [7:0] c_ps2_ech = 8'hEE;
   localparam logic [7:0] c_ps2_f12 = 8'h07;

   localparam int c_rows = 10;
   localparam int c_cols = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BRK     = 2'd1,
      S_EXT     = 2'd2,
      S_EXT_BRK = 2'd3
   } dec_state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] row;
      logic [2:0] col;
   } key_ent_t;

   // Bytes the keyboard sends that carry no key information.
   function automatic logic is_ignored(input logic [7:0] b);
      return (b == c_ps2_e1) || (b == c_ps2_bat) || (b == c_ps2_ack) ||
             (b == c_ps2_rsd) || (b == c_ps2_ech);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pet2001ps2_keymap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pet2001ps2_keymap : {ext, set-2 code} -> {valid, PET row, PET column} |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pet2001ps2_keymap
   import pet2001_pkg::*;
(
   input  logic       ext,
   input  logic [7:0] code,
   output logic       map_valid,
   output logic [3:0] map_row,
   output logic [2:0] map_col
);

   key_ent_t w_ent;

   function automatic key_ent_t ent(input logic [3:0] r, input logic [2:0] c);
      return {1'b1, r, c};
   endfunction

   always_comb begin
      w_ent = '0;
      case ({ext, code})
         9'h015: w_ent = ent(4'd2, 3'd0);   // Q
         9'h024: w_ent = ent(4'd2, 3'd1);   // E
         9'h02C: w_ent = ent(4'd2, 3'd2);   // T
         9'h03C: w_ent = ent(4'd2, 3'd3);   // U
         9'h044: w_ent = ent(4'd2, 3'd4);   // O
         9'h01D: w_ent = ent(4'd3, 3'd0);   // W
         9'h02D: w_ent = ent(4'd3, 3'd1);   // R
         9'h035: w_ent = ent(4'd3, 3'd2);   // Y
         9'h043: w_ent = ent(4'd3, 3'd3);   // I
         9'h04D: w_ent = ent(4'd3, 3'd4);   // P
         9'h01C: w_ent = ent(4'd4, 3'd0);   // A
         9'h023: w_ent = ent(4'd4, 3'd1);   // D
         9'h034: w_ent = ent(4'd4, 3'd2);   // G
         9'h03B: w_ent = ent(4'd4, 3'd3);   // J
         9'h04B: w_ent = ent(4'd4, 3'd4);   // L
         9'h01B: w_ent = ent(4'd5, 3'd0);   // S
         9'h02B: w_ent = ent(4'd5, 3'd1);   // F
         9'h033: w_ent = ent(4'd5, 3'd2);   // H
         9'h042: w_ent = ent(4'd5, 3'd3);   // K
         9'h01A: w_ent = ent(4'd6, 3'd0);   // Z
         9'h021: w_ent = ent(4'd6, 3'd1);   // C
         9'h032: w_ent = ent(4'd6, 3'd2);   // B
         9'h03A: w_ent = ent(4'd6, 3'd3);   // M
         9'h05A: w_ent = ent(4'd6, 3'd5);   // RETURN
         9'h022: w_ent = ent(4'd7, 3'd0);   // X
         9'h02A: w_ent = ent(4'd7, 3'd1);   // V
         9'h031: w_ent = ent(4'd7, 3'd2);   // N
         9'h012: w_ent = ent(4'd8, 3'd0);   // left SHIFT
         9'h059: w_ent = ent(4'd8, 3'd5);   // right SHIFT
         9'h029: w_ent = ent(4'd9, 3'd2);   // SPACE
         9'h066: w_ent = ent(4'd1, 3'd7);   // backspace -> DEL
         9'h16C: w_ent = ent(4'd0, 3'd6);   // HOME
         9'h174: w_ent = ent(4'd0, 3'd7);   // CRSR RIGHT
         9'h172: w_ent = ent(4'd1, 3'd6);   // CRSR DOWN
         default: w_ent = '0;
      endcase
   end

   assign map_valid = w_ent.valid;
   assign map_row   = w_ent.row;
   assign map_col   = w_ent.col;

endmodule
`default_nettype wire

// File: rtl/pet2001ps2_key.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pet2001ps2_key : PS/2 keyboard receiver, prefix decoder, PET matrix  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pet2001ps2_key
   import pet2001_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 16384
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic [3:0] keyrow,
   output logic [7:0] keyin,
   output logic       key_reset
);

   localparam int c_fw = $clog2(FILTER_LEN + 1);
   localparam int c_tw = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_fw-1:0] c_filt_max = c_fw'(FILTER_LEN);
   localparam logic [c_tw-1:0] c_to_max   = c_tw'(TIMEOUT_CYC);
   localparam logic [3:0]      c_row_lim  = 4'(c_rows);

   logic r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
   logic r_filt_lvl, r_armed, r_fall;
   logic [c_fw-1:0] r_filt_cnt;
   logic [9:0] r_shift;
   logic [3:0] r_bit_cnt;
   logic [c_tw-1:0] r_to_cnt;
   logic r_byte_stb, r_frame_err;
   logic [7:0] r_byte;
   dec_state_t r_state;
   logic [c_rows-1:0][c_cols-1:0] r_matrix;

   logic [10:0] w_frame;
   logic w_frame_ok, w_ext, w_brk, w_map_valid;
   logic [3:0] w_map_row;
   logic [2:0] w_map_col;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_clk_meta <= 1'b1;
         r_clk_sync <= 1'b1;
         r_dat_meta <= 1'b1;
         r_dat_sync <= 1'b1;
      end else begin
         r_clk_meta <= ps2_clk;
         r_clk_sync <= r_clk_meta;
         r_dat_meta <= ps2_data;
         r_dat_sync <= r_dat_meta;
      end
   end

   // An edge counts only after a full-length high run followed by a full-length low run.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_filt_lvl <= 1'b1;
         r_filt_cnt <= '0;
         r_armed    <= 1'b0;
         r_fall     <= 1'b0;
      end else begin
         r_fall <= 1'b0;
         if (r_clk_sync != r_filt_lvl) begin
            r_filt_lvl <= r_clk_sync;
            r_filt_cnt <= c_fw'(1);
         end else if (r_filt_cnt != c_filt_max) begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
         end else if (r_filt_lvl) begin
            r_armed <= 1'b1;
         end else if (r_armed) begin
            r_armed <= 1'b0;
            r_fall  <= 1'b1;
         end
      end
   end

   assign w_frame    = {r_dat_sync, r_shift};
   assign w_frame_ok = !w_frame[0] && w_frame[10] && (^w_frame[9:1]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_to_cnt    <= '0;
         r_byte_stb  <= 1'b0;
         r_frame_err <= 1'b0;
         r_byte      <= '0;
      end else begin
         r_byte_stb  <= 1'b0;
         r_frame_err <= 1'b0;
         if (r_fall) begin
            r_to_cnt <= '0;
            if (r_bit_cnt == 4'd10) begin
               r_bit_cnt <= '0;
               if (w_frame_ok) begin
                  r_byte_stb <= 1'b1;
                  r_byte     <= w_frame[8:1];
               end else begin
                  r_frame_err <= 1'b1;
               end
            end else begin
               r_shift   <= {r_dat_sync, r_shift[9:1]};
               r_bit_cnt <= r_bit_cnt + 4'd1;
            end
         end else if (r_bit_cnt != 4'd0) begin
            if (r_to_cnt == c_to_max - 1'b1) begin
               r_bit_cnt <= '0;
               r_to_cnt  <= '0;
            end else begin
               r_to_cnt <= r_to_cnt + 1'b1;
            end
         end
      end
   end

   assign w_ext = (r_state == S_EXT) || (r_state == S_EXT_BRK);
   assign w_brk = (r_state == S_BRK) || (r_state == S_EXT_BRK);

   pet2001ps2_keymap u_keymap (
      .ext       (w_ext),
      .code      (r_byte),
      .map_valid (w_map_valid),
      .map_row   (w_map_row),
      .map_col   (w_map_col)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_matrix  <= '0;
         key_reset <= 1'b0;
      end else begin
         key_reset <= 1'b0;
         if (r_frame_err) begin
            r_state <= S_IDLE;
         end else if (r_byte_stb && !is_ignored(r_byte)) begin
            if (r_state == S_IDLE && r_byte == c_ps2_f0) begin
               r_state <= S_BRK;
            end else if (r_state == S_IDLE && r_byte == c_ps2_e0) begin
               r_state <= S_EXT;
            end else if (r_state == S_EXT && r_byte == c_ps2_f0) begin
               r_state <= S_EXT_BRK;
            end else begin
               r_state <= S_IDLE;
               if (!w_ext && r_byte == c_ps2_f12) begin
                  key_reset <= !w_brk;
               end else if (w_map_valid && w_map_row < c_row_lim) begin
                  r_matrix[w_map_row][w_map_col] <= !w_brk;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         keyin <= 8'hFF;
      end else begin
         keyin <= (keyrow < c_row_lim) ? ~r_matrix[keyrow] : 8'hFF;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pet2001ps2_key.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pet2001ps2_key : directed PS/2 frames, scoreboard on keyin/reset  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pet2001ps2_key;

   localparam int FLT = 4;
   localparam int TO  = 200;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [3:0] keyrow = 4'd0;
   logic [7:0] keyin;
   logic       key_reset;

   always #5 clk = ~clk;

   pet2001ps2_key #(.FILTER_LEN(FLT), .TIMEOUT_CYC(TO)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .keyrow    (keyrow),
      .keyin     (keyin),
      .key_reset (key_reset)
   );

   // kind 0: compare keyin; kind 1: compare key_reset pulse cycles since last kind-1 check
   typedef struct {
      string      name;
      int         kind;
      logic [7:0] exp;
   } exp_t;

   exp_t sb[$];
   logic obs_valid = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   kr_count = 0;

   always @(negedge clk) begin
      exp_t e;
      if (obs_valid) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty: observation with no expected entry");
         end else begin
            e = sb.pop_front();
            if (e.kind == 0) begin
               if (keyin !== e.exp) begin
                  failures++;
                  $display("FAIL %s: keyin got %h expected %h", e.name, keyin, e.exp);
               end
            end else begin
               if (kr_count != int'(e.exp)) begin
                  failures++;
                  $display("FAIL %s: key_reset pulse cycles got %0d expected %0d",
                           e.name, kr_count, e.exp);
               end
               kr_count = 0;
            end
         end
      end
      if (key_reset === 1'b1) kr_count++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      tick(10);
      ps2_clk = 1'b0;
      tick(20);
      ps2_clk = 1'b1;
      tick(10);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad, b, 1'b0};
      for (int i = 0; i < nbits; i++) send_bit(f[i]);
      ps2_data = 1'b1;
      tick(20);
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b0, 11);
   endtask

   task automatic observe(input exp_t e);
      sb.push_back(e);
      obs_valid = 1'b1;
      tick(1);
      obs_valid = 1'b0;
   endtask

   task automatic expect_row(input string name, input logic [3:0] row, input logic [7:0] exp);
      keyrow = row;
      tick(3);
      observe('{name, 0, exp});
   endtask

   task automatic expect_kr(input string name, input int n);
      observe('{name, 1, 8'(n)});
   endtask

   initial begin
      tick(3);
      expect_row("rst_row4", 4'd4, 8'hFF);
      expect_kr("rst_kr", 0);
      reset_n = 1'b1;
      tick(20);
      expect_row("rst_row0", 4'd0, 8'hFF);

      send(8'h1C);
      expect_row("a_make", 4'd4, 8'hFE);
      send(8'hF0); send(8'h1C);
      expect_row("a_break", 4'd4, 8'hFF);

      send(8'h12); send(8'h1C);
      expect_row("shift_a_row8", 4'd8, 8'hFE);
      expect_row("shift_a_row4", 4'd4, 8'hFE);
      send(8'hF0); send(8'h12);
      expect_row("shift_rel_row8", 4'd8, 8'hFF);
      expect_row("shift_rel_row4", 4'd4, 8'hFE);
      send(8'hF0); send(8'h1C);
      expect_row("a_rel_again", 4'd4, 8'hFF);

      send(8'hE0); send(8'h74);
      expect_row("crsr_make", 4'd0, 8'h7F);
      send(8'hE0); send(8'hF0); send(8'h74);
      expect_row("crsr_break", 4'd0, 8'hFF);
      send(8'hE0); send(8'h12);
      expect_row("e0_12_row8", 4'd8, 8'hFF);
      expect_row("e0_12_row0", 4'd0, 8'hFF);

      send(8'hE0); send(8'hAA); send(8'h74);
      expect_row("ign_aa_make", 4'd0, 8'h7F);
      send(8'hE0); send(8'hF0); send(8'hFA); send(8'h74);
      expect_row("ign_fa_break", 4'd0, 8'hFF);

      send(8'hF0);
      send_frame(8'h1C, 1'b1, 11);
      expect_row("bad_parity_row4", 4'd4, 8'hFF);
      send(8'h5A);
      expect_row("prefix_cleared", 4'd6, 8'hDF);
      send(8'hF0); send(8'h5A);
      expect_row("ret_break", 4'd6, 8'hFF);

      send_frame(8'h29, 1'b0, 6);
      tick(TO + 1);
      send(8'h29);
      expect_row("timeout_space", 4'd9, 8'hFB);

      send(8'h59);
      expect_row("multi_row8", 4'd8, 8'hDF);
      expect_row("multi_row9", 4'd9, 8'hFB);
      expect_row("row12_ff", 4'd12, 8'hFF);

      send_frame(8'h5A, 1'b0, 3);
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      tick(5);
      reset_n = 1'b0;
      tick(3);
      expect_row("midrst_row9", 4'd9, 8'hFF);
      expect_kr("midrst_kr", 0);
      reset_n = 1'b1;
      tick(30);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      tick(40);
      expect_row("postrst_row8", 4'd8, 8'hFF);
      expect_row("postrst_row6", 4'd6, 8'hFF);

      send(8'h07);
      expect_kr("f12_pulse", 1);
      expect_row("f12_no_matrix", 4'd0, 8'hFF);
      send(8'hF0); send(8'h07);
      expect_kr("f12_break", 0);
      send(8'h29);
      expect_row("postrst_space", 4'd9, 8'hFB);

      tick(5);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL sb_leftover: %0d entries remain expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pet2001ps2_key.md
PET2001PS2_KEY -- requirements
Module: pet2001ps2_key

Interface
REQ-001 Parameter FILTER_LEN, default 8, meaning: clk cycles ps2_clk must be stable before an edge is accepted.
REQ-002 Parameter TIMEOUT_CYC, default 16384, meaning: clk cycles without an accepted ps2_clk falling edge before a partial frame is abandoned.
REQ-003 Port clk  input  1  system clock; all state on rising edge.
REQ-004 Port reset_n  input  1  reset; one clock, asynchronous assert, active-low.
REQ-005 Port ps2_clk  input  1  PS/2 keyboard clock, asynchronous, idle high.
REQ-006 Port ps2_data  input  1  PS/2 keyboard data, asynchronous, idle high.
REQ-007 Port keyrow  input  4  PET matrix row select, value 0-9 valid.
REQ-008 Port keyin  output  8  PET matrix column sense for the selected row, active-low (0 = key down).
REQ-009 Port key_reset  output  1  one-cycle pulse on F12 make, for the system reset request.

Function
REQ-010 ps2_clk and ps2_data SHALL pass through 2-flop synchronisers before any use.
REQ-011 A ps2_clk falling edge SHALL be accepted only after the synchronised level was high for FILTER_LEN consecutive cycles, then low for FILTER_LEN consecutive cycles.
REQ-012 Receiver SHALL sample ps2_data on each accepted falling edge into an 11-bit frame: start, 8 data LSB-first, odd parity, stop.
REQ-013 A frame SHALL be valid only if start=0, stop=1 and the 9 data+parity bits have odd parity; an invalid frame is discarded and clears decoder prefix state.
REQ-014 If TIMEOUT_CYC cycles elapse after the first accepted edge of a frame without the next one, bit count SHALL return to 0 and the partial frame is discarded.
REQ-015 A valid frame SHALL raise an internal byte strobe exactly one cycle after the stop-bit edge is accepted.
REQ-016 Decoder FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
REQ-017 Transitions: IDLE --F0--> BRK; IDLE --E0--> EXT; EXT --F0--> EXT_BRK; any other byte in any state is a key code, and the FSM returns to IDLE.
REQ-018 Byte E1 and the bytes AA, FA, FE, EE SHALL be ignored with the state unchanged.
REQ-019 A key code SHALL be looked up with {ext, code} in the keymap giving {valid, row[3:0], col[2:0]}; unmapped codes change nothing.
REQ-020 A make (IDLE/EXT) SHALL set matrix bit [row][col]; a break (BRK/EXT_BRK) SHALL clear it, in the cycle after the byte strobe.
REQ-021 Decided keymap entries include: 1C->row4 col0 ('A'); 5A->row6 col5 (RETURN); 12->row8 col0 (left SHIFT); 59->row8 col5 (right SHIFT); 29->row9 col2 (SPACE); E0 74->row0 col7 (CRSR RIGHT); E0 12 unmapped.
REQ-022 Code 07 (F12) make SHALL pulse key_reset for one cycle; it does not touch the matrix.
REQ-023 keyin SHALL be registered: keyin = ~matrix[keyrow] one cycle after keyrow is presented; keyrow 10-15 yields 8'hFF.
REQ-024 Multiple simultaneous pressed keys SHALL all be held; matrix bits are independent.

Reset
REQ-025 reset_n low SHALL clear matrix to all released, keyin to 8'hFF, key_reset to 0, FSM to IDLE, bit count, filter and timeout counters to 0.
REQ-026 Reset mid-frame SHALL discard the partial frame; the first frame after release starts from a new start bit.

Structure
REQ-027 Package pet2001_pkg SHALL hold the PS/2 prefix constants (F0, E0, E1), the decoder state encoding and the matrix dimensions (10 rows, 8 columns).
REQ-028 Sub-module pet2001ps2_keymap SHALL be the combinational {ext, code} -> {valid, row, col} table; the receiver, FSM and matrix live in pet2001ps2_key.

Verification
REQ-029 Send 1C, then keyrow=4 -> keyin=8'hFE; send F0 1C -> keyin=8'hFF.
REQ-030 Send 12 and 1C, keyrow=8 -> 8'hFE, keyrow=4 -> 8'hFE; release 12 only -> row8 8'hFF, row4 still 8'hFE.
REQ-031 Send E0 74 -> row0 keyin=8'h7F; send E0 F0 74 -> 8'hFF; send E0 12 -> no matrix change.
REQ-032 Frame 1C with parity bit flipped -> matrix unchanged; following F0 F0-free 5A -> row6 keyin=8'hDF (prefix cleared, treated as make).
REQ-033 Send 6 bits of a frame, idle TIMEOUT_CYC+1 cycles, then full frame 29 -> row9 keyin=8'hFB.
REQ-034 Assert reset_n low mid-frame with keys down -> all rows 8'hFF, key_reset 0; send 07 after release -> key_reset high exactly one cycle.
